// File: rtl/obi_master_pipelined.sv
// Pipelined OBI manager: controller command stream to the OBI A-channel, with in-order
// R-channel responses returned through a credit-bounded response FIFO.
module obi_master_pipelined #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     req_i,
    output logic                                     gnt_o,
    input  logic                                     we_i,
    input  logic [DATA_WIDTH/8-1:0]                  be_i,
    input  logic [ADDR_WIDTH-1:0]                    addr_i,
    input  logic [DATA_WIDTH-1:0]                    wdata_i,
    output logic                                     rsp_valid_o,
    input  logic                                     rsp_ready_i,
    output logic [DATA_WIDTH-1:0]                    rsp_rdata_o,
    output logic                                     rsp_err_o,
    output logic                                     obi_req_o,
    input  logic                                     obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]                    obi_addr_o,
    output logic                                     obi_we_o,
    output logic [DATA_WIDTH/8-1:0]                  obi_be_o,
    output logic [DATA_WIDTH-1:0]                    obi_wdata_o,
    input  logic                                     obi_rvalid_i,
    output logic                                     obi_rready_o,
    input  logic [DATA_WIDTH-1:0]                    obi_rdata_i,
    input  logic                                     obi_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
    output logic                                     proto_err_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {IDLE, REQ} state_t;
    state_t state_q, state_d;

    logic          accept, issue, beat_ok, pop;
    logic [CW-1:0] iss_cnt, rsp_cnt;

    // per-issued-transaction write flag, consumed when its R beat arrives
    logic [MAX_OUTSTANDING-1:0] we_mem;
    logic [PW-1:0]              we_wptr, we_rptr;

    logic [MAX_OUTSTANDING-1:0][DATA_WIDTH-1:0] rdata_mem;
    logic [MAX_OUTSTANDING-1:0]                 err_mem;
    logic [PW-1:0]                              rsp_wptr, rsp_rptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign obi_req_o   = (state_q == REQ);
    assign gnt_o       = (outstanding_o < CW'(MAX_OUTSTANDING)) && (state_q == IDLE || obi_gnt_i);
    assign accept      = req_i && gnt_o;
    assign issue       = obi_req_o && obi_gnt_i;
    assign beat_ok     = obi_rvalid_i && (iss_cnt != '0);
    assign rsp_valid_o = (rsp_cnt != '0);
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign rsp_rdata_o = rsp_valid_o ? rdata_mem[rsp_rptr] : '0;
    assign rsp_err_o   = rsp_valid_o && err_mem[rsp_rptr];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ:  if (obi_gnt_i && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            obi_addr_o    <= '0;
            obi_we_o      <= 1'b0;
            obi_be_o      <= '0;
            obi_wdata_o   <= '0;
            obi_rready_o  <= 1'b0;
            proto_err_o   <= 1'b0;
            outstanding_o <= '0;
            iss_cnt       <= '0;
            rsp_cnt       <= '0;
            we_mem        <= '0;
            we_wptr       <= '0;
            we_rptr       <= '0;
            rsp_wptr      <= '0;
            rsp_rptr      <= '0;
            rdata_mem     <= '0;
            err_mem       <= '0;
        end else begin
            state_q      <= state_d;
            obi_rready_o <= 1'b1;
            if (accept) begin
                obi_addr_o  <= addr_i;
                obi_we_o    <= we_i;
                obi_be_o    <= be_i;
                obi_wdata_o <= wdata_i;
            end
            if (issue) begin
                we_mem[we_wptr] <= obi_we_o;
                we_wptr         <= nxt(we_wptr);
            end
            // a beat with nothing issued is dropped and flagged until reset
            if (obi_rvalid_i && iss_cnt == '0) proto_err_o <= 1'b1;
            if (beat_ok) begin
                rdata_mem[rsp_wptr] <= we_mem[we_rptr] ? '0 : obi_rdata_i;
                err_mem[rsp_wptr]   <= obi_err_i;
                rsp_wptr            <= nxt(rsp_wptr);
                we_rptr             <= nxt(we_rptr);
            end
            if (pop) rsp_rptr <= nxt(rsp_rptr);
            case ({issue, beat_ok})
                2'b10:   iss_cnt <= iss_cnt + 1'b1;
                2'b01:   iss_cnt <= iss_cnt - 1'b1;
                default: ;
            endcase
            case ({beat_ok, pop})
                2'b10:   rsp_cnt <= rsp_cnt + 1'b1;
                2'b01:   rsp_cnt <= rsp_cnt - 1'b1;
                default: ;
            endcase
            case ({accept, pop})
                2'b10:   outstanding_o <= outstanding_o + 1'b1;
                2'b01:   outstanding_o <= outstanding_o - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_obi_master_pipelined.sv
// Bench for obi_master_pipelined: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based transaction model.
module tb_obi_master_pipelined;
    localparam int MAXO = 4;

    logic        clk_i = 0, reset_i = 1;
    logic        req_i = 0, we_i = 0, rsp_ready_i = 0;
    logic [3:0]  be_i = 0;
    logic [31:0] addr_i = 0, wdata_i = 0;
    logic        gnt_o, rsp_valid_o, rsp_err_o, obi_req_o, obi_we_o, obi_rready_o, proto_err_o;
    logic [31:0] rsp_rdata_o, obi_addr_o, obi_wdata_o;
    logic [3:0]  obi_be_o;
    logic        obi_gnt_i = 0, obi_rvalid_i = 0, obi_err_i = 0;
    logic [31:0] obi_rdata_i = 0;
    logic [2:0]  outstanding_o;

    obi_master_pipelined #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
        .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rready_o(obi_rready_o), .obi_rdata_i(obi_rdata_i),
        .obi_err_i(obi_err_i), .outstanding_o(outstanding_o), .proto_err_o(proto_err_o));

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } cmd_t;
    typedef struct { logic [31:0] d; logic e; } rsp_t;

    // model: pending A-phase, issued-awaiting-beat, responses awaiting pop
    cmd_t a_q[$];
    logic iss_q[$];
    rsp_t rsp_q[$];
    int   m_out = 0;
    logic m_proto = 0, m_rready = 0;
    bit   started = 0;
    int   total = 0, bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic m_gnt();
        return (m_out < MAXO) && (a_q.size() == 0 || obi_gnt_i);
    endfunction

    always @(posedge clk_i) begin
        if (reset_i) begin
            a_q.delete(); iss_q.delete(); rsp_q.delete();
            m_out = 0; m_proto = 0; m_rready = 0;
        end else begin
            bit acc, iss, pp;
            cmd_t c;
            acc = req_i && m_gnt();
            iss = (a_q.size() > 0) && obi_gnt_i;
            pp  = (rsp_q.size() > 0) && rsp_ready_i;
            m_rready = 1;
            if (obi_rvalid_i) begin
                if (iss_q.size() == 0) m_proto = 1;
                else begin
                    rsp_t r;
                    logic w;
                    w   = iss_q.pop_front();
                    r.d = w ? 32'h0 : obi_rdata_i;
                    r.e = obi_err_i;
                    rsp_q.push_back(r);
                end
            end
            if (iss) begin
                c = a_q.pop_front();
                iss_q.push_back(c.we);
            end
            if (pp) void'(rsp_q.pop_front());
            if (acc) begin
                c.addr = addr_i; c.we = we_i; c.be = be_i; c.wdata = wdata_i;
                a_q.push_back(c);
            end
            m_out = m_out + int'(acc) - int'(pp);
        end
    end

    always @(negedge clk_i) begin
        if (started) begin
            chk("gnt", {63'd0, gnt_o}, {63'd0, m_gnt()});
            chk("obi_req", {63'd0, obi_req_o}, {63'd0, a_q.size() > 0});
            if (a_q.size() > 0) begin
                chk("obi_addr", {32'd0, obi_addr_o}, {32'd0, a_q[0].addr});
                chk("obi_we", {63'd0, obi_we_o}, {63'd0, a_q[0].we});
                chk("obi_be", {60'd0, obi_be_o}, {60'd0, a_q[0].be});
                chk("obi_wdata", {32'd0, obi_wdata_o}, {32'd0, a_q[0].wdata});
            end
            chk("rsp_valid", {63'd0, rsp_valid_o}, {63'd0, rsp_q.size() > 0});
            if (rsp_q.size() > 0) begin
                chk("rsp_rdata", {32'd0, rsp_rdata_o}, {32'd0, rsp_q[0].d});
                chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, rsp_q[0].e});
            end
            chk("outstanding", {61'd0, outstanding_o}, 64'(m_out));
            chk("proto_err", {63'd0, proto_err_o}, {63'd0, m_proto});
            chk("rready", {63'd0, obi_rready_o}, {63'd0, m_rready});
        end
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic cmd(input logic we, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        req_i = 1; we_i = we; addr_i = a; be_i = b; wdata_i = d;
    endtask

    initial begin
        tick(); tick();
        started = 1;
        reset_i = 0;
        chk("rst_req", {63'd0, obi_req_o}, 64'd0);
        chk("rst_out", {61'd0, outstanding_o}, 64'd0);
        chk("rst_rdata", {32'd0, rsp_rdata_o}, 64'd0);
        tick();
        chk("rready_after_rst", {63'd0, obi_rready_o}, 64'd1);

        // single read
        cmd(0, 32'hDEADBEEF, 4'hF, 0); obi_gnt_i = 1;
        chk("t2_gnt", {63'd0, gnt_o}, 64'd1);
        tick(); req_i = 0;
        chk("t2_req", {63'd0, obi_req_o}, 64'd1);
        chk("t2_addr", {32'd0, obi_addr_o}, 64'hDEADBEEF);
        tick();
        obi_rvalid_i = 1; obi_rdata_i = 32'h1A73BEEF;
        tick(); obi_rvalid_i = 0;
        chk("t2_rsp_valid", {63'd0, rsp_valid_o}, 64'd1);
        chk("t2_rdata", {32'd0, rsp_rdata_o}, 64'h1A73BEEF);
        chk("t2_err", {63'd0, rsp_err_o}, 64'd0);
        rsp_ready_i = 1; tick(); rsp_ready_i = 0;

        // back-to-back reads, responses held back
        for (int i = 0; i < 4; i++) begin
            cmd(0, 32'h100 + 32'(4 * i), 4'hF, 0); tick();
            chk("t3_addr", {32'd0, obi_addr_o}, 64'h100 + 64'(4 * i));
        end
        req_i = 0;
        chk("t3_out4", {61'd0, outstanding_o}, 64'd4);
        chk("t3_gnt0", {63'd0, gnt_o}, 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            obi_rvalid_i = 1; obi_rdata_i = 32'h1000 + 32'(i); tick();
        end
        obi_rvalid_i = 0;
        rsp_ready_i = 1;
        chk("t3_first", {32'd0, rsp_rdata_o}, 64'h1000);
        tick();
        chk("t3_gnt_after_pop", {63'd0, gnt_o}, 64'd1);
        chk("t3_second", {32'd0, rsp_rdata_o}, 64'h1001);
        tick(); tick(); tick(); rsp_ready_i = 0;
        chk("t3_drained", {61'd0, outstanding_o}, 64'd0);

        // grant stall on a write
        obi_gnt_i = 0; cmd(1, 32'h2000, 4'b0011, 32'hCAFEF00D); tick(); req_i = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_wdata", {32'd0, obi_wdata_o}, 64'hCAFEF00D);
            chk("t4_be", {60'd0, obi_be_o}, 64'h3);
            chk("t4_req", {63'd0, obi_req_o}, 64'd1);
            tick();
        end
        obi_gnt_i = 1; tick();
        obi_rvalid_i = 1; obi_err_i = 1; obi_rdata_i = 32'h55555555; tick();
        obi_rvalid_i = 0; obi_err_i = 0;
        chk("t5_err", {63'd0, rsp_err_o}, 64'd1);
        chk("t5_rdata0", {32'd0, rsp_rdata_o}, 64'd0);
        rsp_ready_i = 1; tick(); rsp_ready_i = 0;
        obi_rvalid_i = 1; tick(); obi_rvalid_i = 0;
        chk("t5_proto", {63'd0, proto_err_o}, 64'd1);
        chk("t5_no_push", {63'd0, rsp_valid_o}, 64'd0);
        tick();
        chk("t5_sticky", {63'd0, proto_err_o}, 64'd1);

        // push and pop together with credits exhausted
        for (int i = 0; i < 4; i++) begin
            cmd(0, 32'h3000 + 32'(4 * i), 4'hF, 0); tick();
        end
        req_i = 0; tick();
        for (int i = 0; i < 3; i++) begin
            obi_rvalid_i = 1; obi_rdata_i = 32'h6000 + 32'(i); tick();
        end
        obi_rdata_i = 32'h6003; rsp_ready_i = 1; tick();
        obi_rvalid_i = 0; rsp_ready_i = 0;
        chk("t6_out", {61'd0, outstanding_o}, 64'd3);
        chk("t6_front", {32'd0, rsp_rdata_o}, 64'h6001);
        rsp_ready_i = 1;
        for (int i = 1; i < 4; i++) begin
            chk("t6_order", {32'd0, rsp_rdata_o}, 64'h6000 + 64'(i));
            tick();
        end
        rsp_ready_i = 0;

        // reset in the middle of a stalled transfer
        obi_gnt_i = 0; cmd(1, 32'h4444, 4'hC, 32'h12345678); tick();
        reset_i = 1; tick(); tick(); reset_i = 0; req_i = 0;
        chk("t1_req", {63'd0, obi_req_o}, 64'd0);
        chk("t1_addr", {32'd0, obi_addr_o}, 64'd0);
        chk("t1_wdata", {32'd0, obi_wdata_o}, 64'd0);
        chk("t1_out", {61'd0, outstanding_o}, 64'd0);
        chk("t1_proto", {63'd0, proto_err_o}, 64'd0);
        chk("t1_rready0", {63'd0, obi_rready_o}, 64'd0);
        tick();
        chk("t1_rready1", {63'd0, obi_rready_o}, 64'd1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            req_i       = ($urandom_range(0, 99) < 60);
            we_i        = $urandom_range(0, 1);
            be_i        = 4'($urandom);
            addr_i      = $urandom;
            wdata_i     = $urandom;
            obi_gnt_i   = ($urandom_range(0, 99) < 70);
            obi_rvalid_i = (iss_q.size() > 0 && $urandom_range(0, 1) == 1) ||
                           ($urandom_range(0, 499) == 0);
            obi_rdata_i = $urandom;
            obi_err_i   = ($urandom_range(0, 7) == 0);
            rsp_ready_i = ($urandom_range(0, 99) < 60);
            reset_i     = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset_i = 0; req_i = 0; obi_rvalid_i = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
